// File: rtl/exec_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : exec_dispatcher
// Purpose  : Dispatches one decoded instruction at a time to NUM_UNITS execution
//            units. The busy-cycle timeout is enabled by defining EXEC_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module exec_dispatcher #(
  parameter int                        XLEN        = 32,
  parameter int                        NUM_UNITS   = 5,
  parameter logic [NUM_UNITS*64-1:0]   UNIT_MASK   = {
    64'hFFFF_0000_0000_0000 & 64'h0000_FFFF_0000_0000 | 64'h0000_FFFF_0000_0000, // u4: 32-47
    64'h003F_0000_F000_0000,                                                       // u3: 28-31, 48-53
    64'hFFC0_0000_0000_0000,                                                       // u2: 54-63
    64'h0000_0000_0FFF_FF00,                                                       // u1: 8-27
    64'h0000_0000_0000_00F0                                                        // u0: 4-7
  },
  parameter int                        BRANCH_UNIT = 4,
  parameter int                        CYC_W       = 8,
  parameter int                        TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [5:0]                in_inst_num,
  output logic [NUM_UNITS-1:0]      unit_start,
  input  logic [NUM_UNITS-1:0]      unit_done,
  input  logic [NUM_UNITS*XLEN-1:0] unit_reg_out,
  input  logic [XLEN-1:0]           unit_pc_out,
  input  logic [NUM_UNITS-1:0]      unit_halt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_reg,
  output logic [XLEN-1:0]           out_pc,
  output logic                      out_illegal,
  output logic                      out_fault,
  output logic [CYC_W-1:0]          out_cycles,
  output logic                      halted
);

  localparam int             SEL_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [1:0]     ST_IDLE     = 2'd0;
  localparam logic [1:0]     ST_BUSY     = 2'd1;
  localparam logic [1:0]     ST_DONE     = 2'd2;
  localparam logic [CYC_W-1:0] CYC_MAX   = '1;
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [CYC_W-1:0] TO_LAST   = CYC_W'(TIMEOUT - 1);
  localparam logic [XLEN-1:0]  ALL_ONES  = '1;
  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  out_reg_q, out_reg_d;
  logic [XLEN-1:0]  out_pc_q, out_pc_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic             halted_q, halted_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;

  logic [XLEN-1:0]      unit_res [NUM_UNITS];
  logic [NUM_UNITS-1:0] unit_hit;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    logic [63:0] mask_row;
    assign mask_row    = UNIT_MASK[u*64 +: 64];
    assign unit_hit[u] = mask_row[in_inst_num];
    assign unit_res[u] = unit_reg_out[u*XLEN +: XLEN];
  end

  // Lowest-numbered matching unit wins.
  logic             match;
  logic [SEL_W-1:0] match_sel;
  always_comb begin
    match     = 1'b0;
    match_sel = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (unit_hit[u]) begin
        match     = 1'b1;
        match_sel = SEL_W'(u);
      end
    end
  end

  logic done_sel;
  logic timeout_hit;
  logic is_branch;
  assign done_sel    = unit_done[sel_q];
  assign timeout_hit = (cycles_q >= TO_LAST);
  assign is_branch   = (sel_q == SEL_W'(BRANCH_UNIT));

`ifndef EXEC_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = timeout_hit;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pc_d      = pc_q;
    out_reg_d = out_reg_q;
    out_pc_d  = out_pc_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    halted_d  = halted_q;
    cycles_d  = cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          pc_d     = in_pc;
          sel_d    = match_sel;
          cycles_d = '0;
          if (match) begin
            state_d = ST_BUSY;
          end else begin
            state_d   = ST_DONE;
            out_reg_d = ALL_ONES;
            out_pc_d  = in_pc + PC_STEP;
            illegal_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cycles_q != CYC_MAX) begin
          cycles_d = cycles_q + CYC_ONE;
        end
        if (done_sel) begin
          state_d   = ST_DONE;
          out_reg_d = unit_res[sel_q];
          out_pc_d  = is_branch ? unit_pc_out : (pc_q + PC_STEP);
          halted_d  = halted_q | unit_halt[sel_q];
        end
`ifdef EXEC_TIMEOUT_EN
        // A done arriving on the limit cycle takes priority over the abort.
        else if (timeout_hit) begin
          state_d   = ST_DONE;
          out_reg_d = ALL_ONES;
          out_pc_d  = pc_q + PC_STEP;
          fault_d   = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d   = ST_IDLE;
          illegal_d = 1'b0;
          fault_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      pc_q      <= '0;
      out_reg_q <= '0;
      out_pc_q  <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      halted_q  <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pc_q      <= pc_d;
      out_reg_q <= out_reg_d;
      out_pc_q  <= out_pc_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      halted_q  <= halted_d;
      cycles_q  <= cycles_d;
    end
  end

  // unit_start is decoded from state so an asynchronous reset drops it at once.
  assign unit_start  = (state_q == ST_BUSY) ? (NUM_UNITS'(1) << sel_q) : '0;
  assign in_ready    = (state_q == ST_IDLE) && !halted_q;
  assign out_valid   = (state_q == ST_DONE);
  assign out_reg     = out_reg_q;
  assign out_pc      = out_pc_q;
  assign out_illegal = illegal_q;
  assign out_fault   = fault_q;
  assign out_cycles  = cycles_q;
  assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_dispatcher
// Purpose  : Directed scoreboard bench for exec_dispatcher (EXEC_TIMEOUT_EN aware).
// Revision : 1.0
// ============================================================================
module tb_exec_dispatcher;

`ifdef EXEC_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [5:0]  in_inst_num;
  logic [4:0]  unit_start;
  logic [4:0]  unit_done;
  logic [159:0] unit_reg_out;
  logic [31:0] unit_pc_out;
  logic [4:0]  unit_halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_reg;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic        out_fault;
  logic [7:0]  out_cycles;
  logic        halted;

  exec_dispatcher #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst_num(in_inst_num),
    .unit_start(unit_start), .unit_done(unit_done), .unit_reg_out(unit_reg_out),
    .unit_pc_out(unit_pc_out), .unit_halt(unit_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg(out_reg), .out_pc(out_pc),
    .out_illegal(out_illegal), .out_fault(out_fault), .out_cycles(out_cycles), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] r;
    logic [31:0] pc;
    logic        ill;
    logic        flt;
    logic [7:0]  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unit-assignment table, independent of the DUT's mask encoding.
  function automatic int exp_unit(input int n);
    if (n >= 4 && n <= 7)                              return 0;
    if (n >= 8 && n <= 27)                             return 1;
    if (n >= 54 && n <= 63)                            return 2;
    if ((n >= 28 && n <= 31) || (n >= 48 && n <= 53))  return 3;
    if (n >= 32 && n <= 47)                            return 4;
    return -1;
  endfunction

  // Offers one instruction; returns at the negedge after the accept edge.
  task automatic drive(input int inst, input logic [31:0] pc);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_inst_num = 6'(inst);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Keeps unit u busy for n cycles; fires done in the last one when fire=1.
  task automatic busy_run(input int u, input int n, input logic [31:0] regv, input logic [31:0] pcout,
                          input logic halt, input logic spurious, input logic fire);
    logic [4:0] onehot;
    onehot = 5'(1) << u;
    for (int k = 1; k <= n; k++) begin
      chk($sformatf("unit_start_busy_u%0d_c%0d", u, k), unit_start, onehot);
      unit_reg_out = {5{~regv}};
      unit_reg_out[u*32 +: 32] = regv;
      unit_pc_out = pcout;
      if (fire && k == n) begin
        unit_done[u] = 1'b1;
        unit_halt[u] = halt;
      end else if (spurious && u != 0) begin
        unit_done[0] = 1'b1;
        unit_halt[0] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      unit_done = '0;
      unit_halt = '0;
    end
  endtask

  task automatic do_instr(input int inst, input logic [31:0] pc, input int n, input logic [31:0] regv,
                          input logic [31:0] pcout, input logic halt, input logic spurious);
    exp_t e;
    int   u;
    u = exp_unit(inst);
    if (u < 0) begin
      e.r = 32'hFFFF_FFFF; e.pc = pc + 32'd4; e.ill = 1'b1; e.flt = 1'b0; e.cyc = 8'd0;
    end else begin
      e.r = regv; e.pc = (u == 4) ? pcout : pc + 32'd4; e.ill = 1'b0; e.flt = 1'b0; e.cyc = 8'(n);
    end
    exp_q.push_back(e);
    drive(inst, pc);
    if (u >= 0) busy_run(u, n, regv, pcout, halt, spurious, 1'b1);
    chk($sformatf("unit_start_idle_inst%0d", inst), unit_start, 5'b0);
  endtask

  // Waits (bounded) for a result, compares against the scoreboard, then accepts it.
  task automatic collect(input int hold, input logic ready_after);
    exp_t e;
    int   waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("out_valid_seen", out_valid, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("out_reg", out_reg, e.r);
      chk("out_pc", out_pc, e.pc);
      chk("out_illegal", out_illegal, e.ill);
      chk("out_fault", out_fault, e.flt);
      chk("out_cycles", out_cycles, e.cyc);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_out_reg", out_reg, e.r);
        chk("hold_out_pc", out_pc, e.pc);
        chk("hold_in_ready", in_ready, 0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_accept", out_valid, 0);
    chk("out_illegal_cleared", out_illegal, 0);
    chk("in_ready_after_accept", in_ready, ready_after);
  endtask

  task automatic reset_mid_busy();
    exp_t e;
    e.r = 32'h0; e.pc = 32'h0; e.ill = 1'b0; e.flt = 1'b0; e.cyc = 8'd0;
    #2 reset = 1'b0;
    #1;
    chk("rst_unit_start", unit_start, 5'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_reg", out_reg, e.r);
    chk("rst_out_pc", out_pc, e.pc);
    chk("rst_out_cycles", out_cycles, e.cyc);
    chk("rst_halted", halted, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  int tbl [13] = '{4, 7, 8, 27, 28, 31, 32, 47, 48, 53, 54, 63, 3};

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst_num = '0;
    unit_done = '0; unit_reg_out = '0; unit_pc_out = '0; unit_halt = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_unit_start", unit_start, 5'b0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_reg", out_reg, 32'h0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_illegal", out_illegal, 0);
    chk("reset_out_fault", out_fault, 0);
    chk("reset_out_cycles", out_cycles, 8'd0);
    chk("reset_halted", halted, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // u1 for three cycles with a spurious done/halt from u0 mixed in
    do_instr(9, 32'h100, 3, 32'h1234, 32'hDEAD_0000, 1'b0, 1'b1);
    chk("spurious_no_halt", halted, 0);
    collect(0, 1'b1);

    // branch unit; result must appear two edges after accept
    exp_q.push_back('{r: 32'hABCD, pc: 32'h80, ill: 1'b0, flt: 1'b0, cyc: 8'd1});
    drive(33, 32'h200);
    busy_run(4, 1, 32'hABCD, 32'h80, 1'b0, 1'b0, 1'b1);
    chk("latency_out_valid", out_valid, 1);
    collect(0, 1'b1);

    // illegal instruction at the top of the address space
    do_instr(0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("illegal_immediate_valid", out_valid, 1);
    collect(0, 1'b1);

    // consumer stalls for five cycles
    do_instr(60, 32'h400, 2, 32'h6060_6060, 32'hDEAD_0000, 1'b0, 1'b0);
    collect(5, 1'b1);

    // unit-map boundaries
    for (int i = 0; i < 13; i++) begin
      do_instr(tbl[i], 32'h1000 + 32'(i * 16), 1, 32'hA000_0000 + 32'(tbl[i]), 32'h0000_0F00, 1'b0, 1'b0);
      collect(0, 1'b1);
    end

`ifdef EXEC_TIMEOUT_EN
    exp_q.push_back('{r: 32'hFFFF_FFFF, pc: 32'h504, ill: 1'b0, flt: 1'b1, cyc: 8'd4});
    drive(9, 32'h500);
    busy_run(1, 4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("timeout_out_fault", out_fault, 1);
    chk("timeout_unit_start", unit_start, 5'b0);
    collect(0, 1'b1);
    chk("fault_cleared", out_fault, 0);
    drive(9, 32'h600);
    busy_run(1, 2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset_mid_busy();
`else
    drive(9, 32'h500);
    repeat (1000) @(negedge clk);
    chk("no_timeout_out_valid", out_valid, 0);
    chk("no_timeout_unit_start", unit_start, 5'b00010);
    chk("no_timeout_out_fault", out_fault, 0);
    reset_mid_busy();
`endif
    chk("post_reset_in_ready", in_ready, 1);

    // halt from u0: result still delivered, then no more accepts
    do_instr(5, 32'h300, 2, 32'h55, 32'hDEAD_0000, 1'b1, 1'b0);
    chk("halted_set", halted, 1);
    collect(0, 1'b0);
    in_valid = 1'b1; in_inst_num = 6'd9; in_pc = 32'h700;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("halted_no_start", unit_start, 5'b0);
      chk("halted_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("halted_no_valid", out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("halted_cleared", halted, 0);
    chk("ready_after_reset", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
